// File: rtl/steer_join_pkg.sv
// steer_join_pkg: shared state encoding and branch tags for the steering join receiver
package steer_join_pkg;
  typedef enum logic {IDLE = 1'b0, ACK_HI = 1'b1} state_t;
  localparam logic BR_A = 1'b0;
  localparam logic BR_B = 1'b1;
endpackage

// File: rtl/steer_join_sync_rx_sync.sv
// sync_chain: multi-flop synchronizer for an asynchronous SEND line
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end
  assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/steer_join_sync_rx.sv
// steer_join_sync_rx: four-phase A/B receiver with round-robin arbitration into a tagged FIFO
module steer_join_sync_rx
  import steer_join_pkg::*;
#(
  parameter int DW          = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             SENDINA,
  input  logic [DW-1:0]    DATAINA,
  output logic             ACKOUTA,
  input  logic             SENDINB,
  input  logic [DW-1:0]    DATAINB,
  output logic             ACKOUTB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [DW-1:0]    OUT_DATA,
  output logic             OUT_BR,
  input  logic             CNT_CLR,
  output logic [CNT_W-1:0] CNTA,
  output logic [CNT_W-1:0] CNTB
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic          br;
    logic [DW-1:0] data;
  } entry_t;
  logic s_a, s_b;
  state_t st_a_q, st_a_d, st_b_q, st_b_d;
  logic rr_q, rr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_q, rd_q;
  entry_t mem_q [DEPTH];
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic full, el_a, el_b, gnt_a, gnt_b, push, pop;
  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (.clk_i(CLK), .rst_ni(RESETN), .d_i(SENDINA), .q_o(s_a));
  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (.clk_i(CLK), .rst_ni(RESETN), .d_i(SENDINB), .q_o(s_b));
  always_comb begin
    full    = cnt_q == (AW+1)'(DEPTH);
    el_a    = st_a_q == IDLE && s_a && !full;
    el_b    = st_b_q == IDLE && s_b && !full;
    gnt_a   = el_a && (!el_b || rr_q == BR_B);
    gnt_b   = el_b && !gnt_a;
    push    = gnt_a || gnt_b;
    pop     = OUT_VALID && OUT_READY;
    // rr_last only moves on contention, so a lone grant never steals the next tie
    rr_d    = (el_a && el_b) ? (gnt_a ? BR_A : BR_B) : rr_q;
    st_a_d  = (st_a_q == IDLE) ? (gnt_a ? ACK_HI : IDLE) : (s_a ? ACK_HI : IDLE);
    st_b_d  = (st_b_q == IDLE) ? (gnt_b ? ACK_HI : IDLE) : (s_b ? ACK_HI : IDLE);
    cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    cnt_a_d = CNT_CLR ? '0 : cnt_a_q + CNT_W'(gnt_a);
    cnt_b_d = CNT_CLR ? '0 : cnt_b_q + CNT_W'(gnt_b);
  end
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      st_a_q  <= IDLE;
      st_b_q  <= IDLE;
      rr_q    <= BR_B;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      st_a_q  <= st_a_d;
      st_b_q  <= st_b_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      if (push) begin
        mem_q[wr_q] <= gnt_a ? entry_t'{br: BR_A, data: DATAINA} : entry_t'{br: BR_B, data: DATAINB};
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
    end
  end
  assign ACKOUTA   = st_a_q == ACK_HI;
  assign ACKOUTB   = st_b_q == ACK_HI;
  assign OUT_VALID = cnt_q != '0;
  assign OUT_DATA  = mem_q[rd_q].data;
  assign OUT_BR    = mem_q[rd_q].br;
  assign CNTA      = cnt_a_q;
  assign CNTB      = cnt_b_q;
endmodule

// File: tb/tb_steer_join_sync_rx.sv
// tb_steer_join_sync_rx: directed/randomized handshakes checked against a token-queue model
module tb_steer_join_sync_rx;
  localparam int DW = 8, DEPTH = 4, SS = 2, CW = 4;
  logic CLK = 0, RESETN = 0;
  logic SENDINA = 0, SENDINB = 0, OUT_READY = 0, CNT_CLR = 0;
  logic [DW-1:0] DATAINA = '0, DATAINB = '0, OUT_DATA;
  logic ACKOUTA, ACKOUTB, OUT_VALID, OUT_BR;
  logic [CW-1:0] CNTA, CNTB;
  int total = 0, bad = 0;
  logic [DW:0] exp_q[$];
  int ca = 0, cb = 0;
  logic rr = 1'b1;
  steer_join_sync_rx #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .SENDINA(SENDINA), .DATAINA(DATAINA), .ACKOUTA(ACKOUTA),
    .SENDINB(SENDINB), .DATAINB(DATAINB), .ACKOUTB(ACKOUTB),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_BR(OUT_BR),
    .CNT_CLR(CNT_CLR), .CNTA(CNTA), .CNTB(CNTB)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic wait_ack(input logic br, input logic val, input int lat, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((br ? ACKOUTB : ACKOUTA) !== val && n < 20);
    chk(tag, n, lat);
  endtask
  task automatic count_push(input logic br);
    if (br) cb = (cb + 1) % (1 << CW);
    else ca = (ca + 1) % (1 << CW);
  endtask
  task automatic hs(input logic br, input logic [DW-1:0] d);
    if (br) begin SENDINB = 1; DATAINB = d; end
    else begin SENDINA = 1; DATAINA = d; end
    wait_ack(br, 1'b1, SS + 1, "ack_rise");
    exp_q.push_back({br, d});
    count_push(br);
    chk("cnt_after_push", br ? CNTB : CNTA, br ? cb : ca);
    if (br) begin SENDINB = 0; DATAINB = DW'($urandom); end
    else begin SENDINA = 0; DATAINA = DW'($urandom); end
    wait_ack(br, 1'b0, SS + 1, "ack_fall");
  endtask
  task automatic drain();
    OUT_READY = 1;
    while (exp_q.size() > 0) begin
      chk("drain_valid", OUT_VALID, 1);
      chk("drain_head", {OUT_BR, OUT_DATA}, exp_q[0]);
      tick();
      void'(exp_q.pop_front());
    end
    OUT_READY = 0;
    chk("drain_empty", OUT_VALID, 0);
  endtask
  task automatic tie(input logic [DW-1:0] da, input logic [DW-1:0] db);
    logic w = (rr == 1'b1) ? 1'b0 : 1'b1;
    SENDINA = 1; SENDINB = 1; DATAINA = da; DATAINB = db;
    repeat (SS + 1) tick();
    chk("tie_winner_ack", w ? ACKOUTB : ACKOUTA, 1);
    chk("tie_loser_wait", w ? ACKOUTA : ACKOUTB, 0);
    tick();
    chk("tie_loser_ack", w ? ACKOUTA : ACKOUTB, 1);
    rr = w;
    exp_q.push_back(w ? {1'b1, db} : {1'b0, da});
    exp_q.push_back(w ? {1'b0, da} : {1'b1, db});
    count_push(1'b0);
    count_push(1'b1);
    chk("tie_cnta", CNTA, ca);
    chk("tie_cntb", CNTB, cb);
    SENDINA = 0; SENDINB = 0;
    repeat (SS + 2) tick();
    chk("tie_acka_low", ACKOUTA, 0);
    chk("tie_ackb_low", ACKOUTB, 0);
  endtask
  initial begin
    logic [DW-1:0] d;
    repeat (4) begin
      SENDINA = 1'($urandom); SENDINB = 1'($urandom);
      DATAINA = DW'($urandom); DATAINB = DW'($urandom);
      OUT_READY = 1'($urandom); CNT_CLR = 1'($urandom);
      tick();
      chk("rst_outs", {ACKOUTA, ACKOUTB, OUT_VALID, OUT_BR, OUT_DATA, CNTA, CNTB}, 0);
    end
    SENDINA = 0; SENDINB = 0; OUT_READY = 0; CNT_CLR = 0;
    tick();
    RESETN = 1;
    tick();
    OUT_READY = 1; SENDINA = 1; DATAINA = 8'h5A;
    wait_ack(1'b0, 1'b1, 3, "single_ack_rise");
    chk("single_valid", OUT_VALID, 1);
    chk("single_br", OUT_BR, 0);
    chk("single_data", OUT_DATA, 8'h5A);
    ca = 1;
    chk("single_cnta", CNTA, 1);
    SENDINA = 0;
    wait_ack(1'b0, 1'b0, 3, "single_ack_fall");
    chk("single_popped", OUT_VALID, 0);
    OUT_READY = 0;
    tie(8'h11, 8'h22);
    chk("tie1_first", exp_q[0], {1'b0, 8'h11});
    drain();
    tie(DW'($urandom), DW'($urandom));
    chk("tie2_b_first", exp_q[0][DW], 1);
    drain();
    for (int i = 0; i < DEPTH; i++) hs(1'(i), DW'($urandom));
    chk("full_cnt_valid", OUT_VALID, 1);
    d = DW'($urandom);
    SENDINA = 1; DATAINA = d;
    repeat (6) tick();
    chk("full_held_ack", ACKOUTA, 0);
    chk("full_head", {OUT_BR, OUT_DATA}, exp_q[0]);
    OUT_READY = 1;
    tick();
    OUT_READY = 0;
    void'(exp_q.pop_front());
    chk("no_write_through", ACKOUTA, 0);
    tick();
    chk("full_release_ack", ACKOUTA, 1);
    exp_q.push_back({1'b0, d});
    count_push(1'b0);
    chk("full_release_cnta", CNTA, ca);
    SENDINA = 0;
    wait_ack(1'b0, 1'b0, 3, "full_release_fall");
    drain();
    CNT_CLR = 1;
    tick();
    CNT_CLR = 0;
    ca = 0; cb = 0;
    chk("clr_cnta", CNTA, 0);
    chk("clr_cntb", CNTB, 0);
    repeat (17) begin
      hs(1'b0, DW'($urandom));
      drain();
    end
    chk("wrap_cnta", CNTA, 1);
    d = DW'($urandom);
    SENDINA = 1; DATAINA = d;
    repeat (SS) tick();
    CNT_CLR = 1;
    tick();
    CNT_CLR = 0;
    chk("clr_push_ack", ACKOUTA, 1);
    chk("clr_push_cnta", CNTA, 0);
    chk("clr_push_head", {OUT_VALID, OUT_BR, OUT_DATA}, {2'b10, d});
    ca = 0;
    exp_q.push_back({1'b0, d});
    SENDINA = 0;
    wait_ack(1'b0, 1'b0, 3, "clr_push_fall");
    drain();
    repeat (3) begin
      for (int i = 0; i < DEPTH; i++) hs(1'($urandom), DW'($urandom));
      drain();
    end
    SENDINA = 1; SENDINB = 1;
    repeat (SS + 3) tick();
    chk("pre_rst_acks", {ACKOUTA, ACKOUTB}, 2'b11);
    #2 RESETN = 0;
    #1;
    chk("async_rst_acks", {ACKOUTA, ACKOUTB}, 0);
    chk("async_rst_state", {OUT_VALID, CNTA, CNTB}, 0);
    SENDINA = 0; SENDINB = 0;
    exp_q.delete();
    ca = 0; cb = 0; rr = 1'b1;
    repeat (2) tick();
    RESETN = 1;
    tick();
    chk("post_rst_empty", {OUT_VALID, CNTA, CNTB}, 0);
    hs(1'b0, DW'($urandom));
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
